// File: rtl/transferencia_dma.sv
// DMA beat engine between the SD DAT-line FIFO and the system-memory port.
// Moves one DATA_W word per beat in either direction and reports progress and completion.
module transferencia_dma #(
  parameter int DATA_W = 32,
  parameter int ADR_W  = 64,
  parameter int LEN_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET_L,
  input  logic              Permiso_Transf,
  input  logic              Data_Transfer_Direction_Select,
  input  logic [LEN_W-1:0]  DAT_LEN,
  input  logic [ADR_W-1:0]  DAT_ADR,
  input  logic              Abortar,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rdata,
  input  logic              fifo_empty,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wdata,
  input  logic              fifo_full,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADR_W-1:0]  mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [LEN_W-1:0]  transfer_data_length,
  output logic              transferencia_finalizada,
  output logic              abortada,
  output logic              ocupado
);

  localparam logic [LEN_W:0]   BEAT_L = (LEN_W+1)'(DATA_W/8);
  localparam logic [ADR_W-1:0] BEAT_A = ADR_W'(DATA_W/8);

  typedef enum logic [6:0] {
    IDLE     = 7'b0000001,
    C2H_POP  = 7'b0000010,
    C2H_LAT  = 7'b0000100,
    C2H_WR   = 7'b0001000,
    H2C_RD   = 7'b0010000,
    H2C_PUSH = 7'b0100000,
    DONE     = 7'b1000000
  } state_t;

  state_t              state_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    cnt_q;
  logic [ADR_W-1:0]    adr_q;
  logic [DATA_W-1:0]   data_q;
  logic                dir_q;
  logic                abortada_q;
  logic                fifo_rd_en_q;
  logic                fifo_wr_en_q;
  logic                mem_req_q;
  logic                mem_we_q;

  logic [LEN_W:0]      sum_d;
  logic [LEN_W-1:0]    cnt_adv_d;
  logic [ADR_W-1:0]    adr_adv_d;
  logic                beat_go_d;

  // Count is clipped to the latched length so a partial last beat reports exact bytes.
  always_comb begin
    sum_d     = {1'b0, cnt_q} + BEAT_L;
    cnt_adv_d = (sum_d >= {1'b0, len_q}) ? len_q : sum_d[LEN_W-1:0];
    adr_adv_d = adr_q + BEAT_A;
    beat_go_d = ((state_q == C2H_WR) && mem_ack) ||
                ((state_q == H2C_PUSH) && !fifo_full);
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q      <= IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      adr_q        <= '0;
      data_q       <= '0;
      dir_q        <= 1'b0;
      abortada_q   <= 1'b0;
      fifo_rd_en_q <= 1'b0;
      fifo_wr_en_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      fifo_rd_en_q <= 1'b0;
      fifo_wr_en_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (Permiso_Transf) begin
            len_q      <= DAT_LEN;
            adr_q      <= DAT_ADR;
            dir_q      <= Data_Transfer_Direction_Select;
            cnt_q      <= '0;
            abortada_q <= 1'b0;
            if (DAT_LEN == '0) begin
              state_q <= DONE;
            end else if (Data_Transfer_Direction_Select) begin
              state_q <= C2H_POP;
            end else begin
              // A read already requested on entry can no longer be aborted.
              state_q   <= H2C_RD;
              mem_req_q <= ~Abortar;
              mem_we_q  <= 1'b0;
            end
          end
        end
        C2H_POP: begin
          if (Abortar) begin
            state_q    <= DONE;
            abortada_q <= 1'b1;
          end else if (!fifo_empty) begin
            fifo_rd_en_q <= 1'b1;
            state_q      <= C2H_LAT;
          end
        end
        C2H_LAT: begin
          data_q    <= fifo_rdata;
          mem_req_q <= 1'b1;
          mem_we_q  <= 1'b1;
          state_q   <= C2H_WR;
        end
        C2H_WR: begin
          // Beat advance below handles the ack.
        end
        H2C_RD: begin
          if (!mem_req_q) begin
            if (Abortar) begin
              state_q    <= DONE;
              abortada_q <= 1'b1;
            end else begin
              mem_req_q <= 1'b1;
            end
          end else if (mem_ack) begin
            data_q    <= mem_rdata;
            mem_req_q <= 1'b0;
            state_q   <= H2C_PUSH;
          end
        end
        H2C_PUSH: begin
          if (!fifo_full) fifo_wr_en_q <= 1'b1;
        end
        DONE: begin
          if (!Permiso_Transf) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (beat_go_d) begin
        adr_q     <= adr_adv_d;
        cnt_q     <= cnt_adv_d;
        mem_req_q <= 1'b0;
        mem_we_q  <= 1'b0;
        if (cnt_adv_d == len_q) begin
          state_q <= DONE;
        end else if (Abortar) begin
          state_q    <= DONE;
          abortada_q <= 1'b1;
        end else if (dir_q) begin
          state_q <= C2H_POP;
        end else begin
          state_q   <= H2C_RD;
          mem_req_q <= 1'b1;
        end
      end
    end
  end

  assign fifo_rd_en               = fifo_rd_en_q;
  assign fifo_wr_en               = fifo_wr_en_q;
  assign fifo_wdata               = data_q;
  assign mem_req                  = mem_req_q;
  assign mem_we                   = mem_we_q;
  assign mem_adr                  = adr_q;
  assign mem_wdata                = data_q;
  assign transfer_data_length     = cnt_q;
  assign abortada                 = abortada_q;
  assign transferencia_finalizada = (state_q == DONE);
  assign ocupado                  = !((state_q == IDLE) || (state_q == DONE));

endmodule

// File: doc/transferencia_dma.md
# transferencia_dma

Parametrised DMA transfer engine for the SD host data path, placed between the DAT-line data FIFO and the system-memory port. It takes a byte length, a start address and a direction, then moves data one beat at a time:

- Card-to-host: pops words from the FIFO and writes them to memory.
- Host-to-card: reads words from memory and pushes them into the FIFO.

It counts transferred bytes, supports abort, and signals completion with a level handshake on `Permiso_Transf` / `transferencia_finalizada`.

## Interface
- `DATA_W`, 32: FIFO and memory data width in bits; multiple of 8.
- `ADR_W`, 64: memory address width.
- `LEN_W`, 16: transfer-length width, in bytes.
- `CLK` input 1: single clock; all logic on the rising edge.
- `RESET_L` input 1: asynchronous, active-low reset.
- `Permiso_Transf` input 1: start request, level. Must be held high until `transferencia_finalizada` is seen.
- `Data_Transfer_Direction_Select` input 1: 1 = card-to-host, 0 = host-to-card. Sampled at start.
- `DAT_LEN` input LEN_W: transfer length in bytes. Sampled at start.
- `DAT_ADR` input ADR_W: start byte address. Sampled at start.
- `Abortar` input 1: abort request, level.
- `fifo_rd_en` output 1: FIFO pop strobe. Read data arrives the following cycle.
- `fifo_rdata` input DATA_W: FIFO read data.
- `fifo_empty` input 1: FIFO empty flag.
- `fifo_wr_en` output 1: FIFO push strobe.
- `fifo_wdata` output DATA_W: FIFO write data.
- `fifo_full` input 1: FIFO full flag.
- `mem_req` output 1: memory request.
- `mem_we` output 1: 1 = write, 0 = read.
- `mem_adr` output ADR_W: memory beat address.
- `mem_wdata` output DATA_W: memory write data.
- `mem_ack` input 1: completes the request in the cycle it is sampled high with `mem_req`.
- `mem_rdata` input DATA_W: memory read data, valid with `mem_ack`.
- `transfer_data_length` output LEN_W: bytes transferred so far.
- `transferencia_finalizada` output 1: transfer ended, normally or by abort.
- `abortada` output 1: the ended transfer was aborted.
- `ocupado` output 1: engine active, i.e. state is neither IDLE nor DONE.

## Operation
- Beat size: BEAT = DATA_W/8 bytes.
- State encoding is one-hot, 7 states: IDLE, C2H_POP, C2H_LAT, C2H_WR, H2C_RD, H2C_PUSH, DONE.
- IDLE, when `Permiso_Transf`=1:
  - Latch length, address and direction.
  - Clear `transfer_data_length` and `abortada`.
  - If the latched length is 0, go to DONE.
  - Otherwise go to C2H_POP (direction=1) or H2C_RD (direction=0).
- C2H_POP:
  - If `Abortar` is high, go to DONE with `abortada`=1.
  - Else if `fifo_empty`=0, pulse `fifo_rd_en` for 1 cycle and go to C2H_LAT.
  - Else wait in C2H_POP.
- C2H_LAT: capture `fifo_rdata` into the data register, then go to C2H_WR.
- C2H_WR:
  - Drive `mem_req`=1 and `mem_we`=1, with `mem_adr`/`mem_wdata` held stable until `mem_ack`.
  - On ack, advance the beat (rule below).
- H2C_RD:
  - If `Abortar` is high and no request has been issued yet, go to DONE with `abortada`=1.
  - Otherwise drive `mem_req`=1 and `mem_we`=0 until `mem_ack`; capture `mem_rdata` on ack and go to H2C_PUSH.
- H2C_PUSH:
  - When `fifo_full`=0, pulse `fifo_wr_en` with `fifo_wdata` = the captured word, then advance the beat.
  - Otherwise wait in H2C_PUSH.
- Beat advance:
  - Address increments by BEAT, modulo 2^ADR_W.
  - Count becomes min(count+BEAT, latched length), computed in LEN_W+1 bits with no overflow.
  - If the new count equals the latched length, go to DONE.
  - Otherwise go to the direction's first state, but go to DONE with `abortada`=1 if `Abortar` is high.
- A partial final beat still moves a full word; only the count is clipped.
- An abort never cuts a memory handshake: once `mem_req` is asserted it stays high until `mem_ack`.
- DONE:
  - `transferencia_finalizada`=1; `transfer_data_length` and `abortada` are held.
  - When `Permiso_Transf`=0, go to IDLE.
  - In the IDLE cycle `transferencia_finalizada` falls; the count and `abortada` stay until the next start.
- `Data_Transfer_Direction_Select`, `DAT_LEN` and `DAT_ADR` are ignored outside the start cycle.

## Timing
- Reset values:
  - State = IDLE.
  - All outputs 0: `fifo_rd_en`, `fifo_wr_en`, `fifo_wdata`, `mem_req`, `mem_we`, `mem_adr`, `mem_wdata`, `transfer_data_length`, `transferencia_finalizada`, `abortada`, `ocupado`.
  - Internal address and length registers 0.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- Start latency: 1 cycle. The start edge samples `Permiso_Transf`; the first beat state is active on the next cycle.
- C2H beat, minimum 3 cycles (POP, LAT, WR with ack in the first WR cycle); one extra cycle per wait cycle on empty or ack.
- H2C beat, minimum 2 cycles (RD with immediate ack, PUSH not full).
- `transferencia_finalizada` rises the cycle after the last ack/push, or the cycle after an abort is taken.
- Reset asserted mid-transfer: immediately returns to reset values. Any memory request is dropped, and no further pops or pushes occur.
- `Permiso_Transf` low in any active state: ignored. The engine only stops via completion or `Abortar`.

## Test plan
- Reset mid C2H_WR with `mem_req`=1 -> all outputs 0 asynchronously; IDLE after release; the next start works.
- C2H, DATA_W=32, `DAT_LEN`=8, `DAT_ADR`=0x1000, FIFO holding 0xA1, 0xB2, ack immediate:
  - Two memory writes: 0xA1 @0x1000, then 0xB2 @0x1004.
  - `transfer_data_length`=8; finalizada 7 cycles after the start edge; it drops one cycle after `Permiso_Transf`=0.
- H2C, `DAT_LEN`=6, `fifo_full` high for 3 cycles on beat 2:
  - Two reads, at 0x0 and 0x4; two pushes; `transfer_data_length` sequence 4 then 6.
  - No push while full; `abortada`=0.
- `DAT_LEN`=0 -> finalizada the cycle after start; no `mem_req`, `fifo_rd_en` or `fifo_wr_en`; count 0.
- Address wrap and abort:
  - Start at `DAT_ADR`=0xFFFF_FFFF_FFFF_FFFC with `DAT_LEN`=16; beat 2 goes to address 0x0.
  - Assert `Abortar` while `mem_req` is pending on beat 2 -> ack completes; DONE with count 8 and `abortada`=1; no third beat.
